// File: rtl/alu_control_decode.sv
// Four-state fetch/decode/execute controller with a 2-bit PC and a small ALU.
// One instruction takes FETCH, DECODE and EXECUTE; the result is strobed out on s.
module alu_control_decode #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              str,
    input  logic [7:0]        instr,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [1:0]        pc,
    output logic [1:0]        add1,
    output logic [1:0]        add2,
    output logic [1:0]        opcode,
    output logic [DATA_W-1:0] out,
    output logic              s,
    output logic [1:0]        state,
    output logic [1:0]        next_state
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] FETCH   = 2'b01;
    localparam logic [1:0] DECODE  = 2'b10;
    localparam logic [1:0] EXECUTE = 2'b11;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [1:0]        pc_q;
    logic [1:0]        opcode_q;
    logic [1:0]        add1_q;
    logic [1:0]        add2_q;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] out_d;
    logic              s_q;
    logic              unused_instr_bits;

    // The two low instruction bits are reserved.
    assign unused_instr_bits = ^instr[1:0];

    always_comb begin
        state_d = IDLE;
        if (!reset) begin
            case (state_q)
                IDLE:    state_d = str ? FETCH : IDLE;
                FETCH:   state_d = DECODE;
                DECODE:  state_d = EXECUTE;
                EXECUTE: state_d = str ? FETCH : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        out_d = '0;
        case (opcode_q)
            2'b00:   out_d = op1 + op2;
            2'b01:   out_d = op1 - op2;
            2'b10:   out_d = op1 & op2;
            default: out_d = op1 | op2;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= 2'd0;
            opcode_q <= 2'd0;
            add1_q   <= 2'd0;
            add2_q   <= 2'd0;
            out_q    <= '0;
            s_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= (state_q == EXECUTE);
            if (state_q == DECODE) begin
                opcode_q <= instr[7:6];
                add1_q   <= instr[5:4];
                add2_q   <= instr[3:2];
            end
            // Result capture and PC advance happen together as the instruction retires.
            if (state_q == EXECUTE) begin
                out_q <= out_d;
                pc_q  <= pc_q + 2'd1;
            end
        end
    end

    assign pc         = pc_q;
    assign add1       = add1_q;
    assign add2       = add2_q;
    assign opcode     = opcode_q;
    assign out        = out_q;
    assign s          = s_q;
    assign state      = state_q;
    assign next_state = state_d;

endmodule

// File: tb/tb_alu_control_decode.sv
// Bench for alu_control_decode: models the instruction and register banks,
// runs directed vectors, random back-to-back programs and reset corner cases.
module tb_alu_control_decode;

    logic       clk;
    logic       reset;
    logic       str;
    logic [7:0] instr;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [1:0] pc;
    logic [1:0] add1;
    logic [1:0] add2;
    logic [1:0] opcode;
    logic [7:0] out;
    logic       s;
    logic [1:0] state;
    logic [1:0] next_state;

    logic [7:0] imem [4];
    logic [7:0] regs [4];

    int checks = 0;
    int errors = 0;
    int pc_model = 0;

    assign instr = imem[pc];
    assign op1   = regs[add1];
    assign op2   = regs[add2];

    alu_control_decode #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset), .str(str), .instr(instr), .op1(op1), .op2(op2),
        .pc(pc), .add1(add1), .add2(add2), .opcode(opcode), .out(out), .s(s),
        .state(state), .next_state(next_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] exp_opcode;
        logic [1:0] exp_add1;
        logic [1:0] exp_add2;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = (a + b) % 256;
            1:       r = (a - b + 256) % 256;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return r[7:0];
    endfunction

    initial begin
        int cnt;
        int rounds;
        int base_pc;
        logic [7:0] ins;
        logic [7:0] expv;

        reset = 1'b1;
        str   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem[i] = 8'h00;
            regs[i] = 8'h00;
        end
        vecs[0] = '{8'b00000100, 8'h01, 8'h02, 2'b00, 2'b00, 2'b01, 8'h03};
        vecs[1] = '{8'b01011000, 8'h02, 8'h02, 2'b01, 2'b01, 2'b10, 8'h00};
        vecs[2] = '{8'b01000100, 8'h00, 8'h01, 2'b01, 2'b00, 2'b01, 8'hFF};
        vecs[3] = '{8'b00000100, 8'hFF, 8'h02, 2'b00, 2'b00, 2'b01, 8'h01};
        vecs[4] = '{8'b10000100, 8'h0F, 8'h3C, 2'b10, 2'b00, 2'b01, 8'h0C};
        vecs[5] = '{8'b11000100, 8'h0F, 8'h3C, 2'b11, 2'b00, 2'b01, 8'h3F};
        vecs[6] = '{8'b11100111, 8'h50, 8'h05, 2'b11, 2'b10, 2'b01, 8'h55};

        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_pc", pc, 0);
        check("rst_out", out, 0);
        check("rst_s", s, 0);
        check("rst_opcode", opcode, 0);
        check("rst_nextstate", next_state, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_hold", state, 0);

        // Directed vectors: one instruction each, str dropped mid-instruction.
        for (int v = 0; v < 7; v++) begin
            imem[pc_model] = vecs[v].instr;
            regs[vecs[v].exp_add1] = vecs[v].a;
            regs[vecs[v].exp_add2] = vecs[v].b;
            str = 1'b1;
            @(negedge clk);
            check("vec_fetch", state, 1);
            str = 1'b0;
            @(negedge clk);
            check("vec_decode", state, 2);
            @(negedge clk);
            check("vec_exec", state, 3);
            check("vec_opcode", opcode, vecs[v].exp_opcode);
            check("vec_add1", add1, vecs[v].exp_add1);
            check("vec_add2", add2, vecs[v].exp_add2);
            check("vec_s_low", s, 0);
            @(negedge clk);
            pc_model = (pc_model + 1) % 4;
            check("vec_out", out, vecs[v].exp_out);
            check("vec_s", s, 1);
            check("vec_pc", pc, pc_model);
            check("vec_idle", state, 0);
            @(negedge clk);
            check("vec_s_drop", s, 0);
            check("vec_out_hold", out, vecs[v].exp_out);
            check("vec_opcode_hold", opcode, vecs[v].exp_opcode);
            $display("vec %0d instr=%b out=%h pc=%0d", v, vecs[v].instr, out, pc);
        end

        // Random programs run back to back; str drops during the last one.
        for (rounds = 0; rounds < 4; rounds++) begin
            for (int i = 0; i < 4; i++) begin
                imem[i] = 8'($urandom);
                regs[i] = 8'($urandom);
            end
            base_pc = pc_model;
            str = 1'b1;
            for (int k = 0; k < 8; k++) begin
                ins  = imem[pc_model];
                expv = alu_ref(int'(ins[7:6]), int'(regs[ins[5:4]]), int'(regs[ins[3:2]]));
                cnt = 0;
                do begin
                    @(negedge clk);
                    cnt++;
                end while (s !== 1'b1 && cnt < 8);
                pc_model = (pc_model + 1) % 4;
                check("rnd_s_seen", s, 1);
                check("rnd_gap", cnt, (k == 0) ? 4 : 3);
                check("rnd_out", out, expv);
                check("rnd_pc", pc, pc_model);
                $display("rnd %0d.%0d instr=%b out=%h pc=%0d", rounds, k, ins, out, pc);
                if (k == 6) str = 1'b0;
            end
            check("rnd_end_idle", state, 0);
            check("rnd_pc_wrap", pc, (base_pc + 8) % 4);
            repeat (2) @(negedge clk);
            check("rnd_stay_idle", state, 0);
            check("rnd_s_quiet", s, 0);
        end

        // Asynchronous reset pulse mid-run, away from any clock edge.
        str = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_state", state, 0);
        check("async_pc", pc, 0);
        check("async_out", out, 0);
        check("async_s", s, 0);
        check("async_next", next_state, 0);
        @(negedge clk);
        check("held_next", next_state, 0);
        check("held_state", state, 0);
        str = 1'b0;
        reset = 1'b0;
        pc_model = 0;
        @(negedge clk);
        check("post_rst_idle", state, 0);

        // Reset landing in EXECUTE aborts the instruction.
        imem[0] = 8'b00000100;
        regs[0] = 8'h11;
        regs[1] = 8'h22;
        str = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_exec", state, 3);
        #2;
        reset = 1'b1;
        @(negedge clk);
        check("abort_s", s, 0);
        check("abort_pc", pc, 0);
        check("abort_out", out, 0);
        check("abort_state", state, 0);
        str = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_idle", state, 0);
            check("abort_quiet", s, 0);
        end
        $display("reset scenarios done pc=%0d state=%0d", pc, state);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_control_decode.md
ALU_CONTROL_DECODE -- requirements
Module: alu_control_decode

Interface
REQ-001 Clocking: one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 8, operand/result width; all requirements below use 8.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  async active-high reset.
REQ-005 str  input  1  start/run request; level-sensitive.
REQ-006 instr  input  8  instruction word for current pc, from external instruction bank.
REQ-007 op1  input  8  operand A, external register-bank read of add1.
REQ-008 op2  input  8  operand B, external register-bank read of add2.
REQ-009 pc  output  2  program counter, instruction-bank address.
REQ-010 add1  output  2  decoded source-A register address.
REQ-011 add2  output  2  decoded source-B register address.
REQ-012 opcode  output  2  decoded ALU operation.
REQ-013 out  output  8  registered ALU result.
REQ-014 s  output  1  result-valid strobe, one cycle wide.
REQ-015 state  output  2  current FSM state, registered.
REQ-016 next_state  output  2  FSM next state, combinational.

Function
REQ-017 Instruction format: opcode=instr[7:6], add1=instr[5:4], add2=instr[3:2]; instr[1:0] reserved, ignored.
REQ-018 FSM encoding: IDLE=00, FETCH=01, DECODE=10, EXECUTE=11; state<=next_state every rising edge.
REQ-019 IDLE: next FETCH if str=1, else IDLE; pc held.
REQ-020 FETCH: unconditional next DECODE; instr sampled as addressed by pc.
REQ-021 DECODE: on the edge leaving DECODE, opcode/add1/add2 register from instr; next EXECUTE.
REQ-022 Decoded fields hold their values in all other states.
REQ-023 EXECUTE: op1/op2 (read combinationally by external bank via add1/add2) are valid; on the edge leaving EXECUTE, out registers the ALU result, s is set to 1, pc increments.
REQ-024 EXECUTE next state: FETCH if str=1, else IDLE.
REQ-025 s is 1 only in the cycle after EXECUTE, 0 in all other cycles.
REQ-026 ALU ops: 00 out=op1+op2; 01 out=op1-op2; 10 out=op1&op2; 11 out=op1|op2.
REQ-027 Arithmetic is modulo 256: carry and borrow discarded, no flags.
REQ-028 out holds its last value except when updated at EXECUTE.
REQ-029 pc wraps 3->0 on increment.
REQ-030 One instruction completes every 3 cycles while str stays 1.
REQ-031 str dropping mid-instruction does not abort it; the instruction finishes, then FSM goes to IDLE.

Reset
REQ-032 reset=1 immediately forces state=IDLE, pc=0, opcode=0, add1=0, add2=0, out=0, s=0, independent of clk.
REQ-033 While reset=1, next_state reads IDLE and all registers hold reset values.
REQ-034 Reset asserted during any state, including EXECUTE, aborts the instruction: no s pulse, no pc increment, out stays 0.
REQ-035 After reset deasserts, operation starts only on str=1 from IDLE.

Verification
REQ-036 Pulse reset mid-run -> state=00, pc=0, out=00, s=0 immediately; next_state=00 while reset held.
REQ-037 str=1, instr=00000100, op1=01, op2=02 -> opcode=00, add1=00, add2=01 after DECODE; out=03 and s=1 one cycle after EXECUTE; pc=1.
REQ-038 instr=01011000, op1=02, op2=02 -> opcode=01, add1=01, add2=10; out=00.
REQ-039 opcode 01, op1=00, op2=01 -> out=FF; opcode 00, op1=FF, op2=02 -> out=01; opcode 10 and 11 with op1=0F, op2=3C -> out=0C, then out=3F.
REQ-040 str held 1 for four instructions -> s pulses every 3 cycles; pc sequence 1,2,3,0.
REQ-041 Reset asserted during EXECUTE -> s stays 0, pc=0, state=IDLE; str=0 after one instruction -> FSM returns to IDLE and stays there.
